neopix_frame_sequencer: RTL
===========================

Name: neopix_frame_sequencer

Overview:
Reads a frame of pixel words from the 512x32 pixel RAM read port and streams them to the NeoPixel bit serializer over a valid/ready handshake. Issues read addresses ahead of demand and absorbs the RAM's fixed registered read latency in a small skid FIFO. After the last pixel has been shifted out, it holds the WS2812 reset/latch gap, then signals frame completion to the SPI command side.

Parameters:
ADDR_W, 9, RAM read address width; frame holds up to 2**ADDR_W pixels.
DATA_W, 32, RAM word width; pixel colour is bits [23:0] in GRB order, upper bits ignored.
RD_LATENCY, 2, clock edges from the RAM sampling an address to valid data on ram_q_i (registered address plus registered output).
FIFO_DEPTH, 4, skid FIFO entries; power of two, at least RD_LATENCY+1.
RESET_CYCLES, 15000, latch-gap length in clk_i cycles (300 us at 50 MHz).

Ports:
clk_i  in  1  system clock; everything is in this one clock domain.
rst_n_i  in  1  asynchronous active-low reset.
start_i  in  1  single-cycle frame start request.
num_pixels_i  in  ADDR_W+1  pixel count for the frame, sampled on an accepted start.
busy_o  out  1  high from an accepted start until done_o.
done_o  out  1  one-cycle pulse when the frame and its latch gap are complete.
ram_rdaddr_o  out  ADDR_W  read address to the RAM read port (registered output).
ram_q_i  in  DATA_W  RAM read data.
pix_data_o  out  24  pixel to the serializer; this is the FIFO head bits [23:0].
pix_valid_o  out  1  pix_data_o is valid.
pix_ready_i  in  1  serializer accepts a pixel when valid and ready are both high.
ser_idle_i  in  1  serializer has finished shifting all bits.

Behaviour:
- Reset values: busy_o=0, done_o=0, ram_rdaddr_o=0, pix_valid_o=0, pix_data_o=0. On reset the FIFO is emptied, the in-flight pipe is cleared and the FSM returns to IDLE. Reset mid-frame therefore aborts the frame with no done_o pulse.
- FSM states:
  - IDLE: start_i loads N = min(num_pixels_i, 2**ADDR_W), zeroes the issue and send counters, sets busy_o on the next edge, and goes to STREAM. If N=0 it goes directly to LATCH.
  - STREAM: issue reads and send pixels (rules below). When send_count reaches N, go to WAIT_IDLE.
  - WAIT_IDLE: wait for ser_idle_i=1, then load the latch counter with RESET_CYCLES-1 and go to LATCH.
  - LATCH: decrement the counter each cycle. At 0, assert done_o for one cycle, clear busy_o in the same cycle, and go to IDLE.
- start_i is ignored while busy_o=1.
- Read issue:
  - A read is issued in a cycle when issue_count<N and (fifo_count + inflight) < FIFO_DEPTH.
  - ram_rdaddr_o <= issue_count, issue_count++, and a 1 enters an RD_LATENCY-deep valid shift pipe.
  - The pipe output writes ram_q_i into the FIFO. The credit rule guarantees the FIFO never overflows.
  - Addresses run 0..N-1 with no wrap; a frame of 512 pixels ends at address 511.
- Send:
  - pix_valid_o = FIFO non-empty (registered count).
  - When pix_valid_o && pix_ready_i, pop the FIFO and send_count++.
  - pix_data_o stays stable while valid && !ready.
  - Push and pop in the same cycle leave the count unchanged.
- Throughput: with pix_ready_i held high, one pixel per cycle is sustained after the initial fill latency. The first pix_valid_o appears RD_LATENCY+1 cycles after the STREAM entry edge.
- Back-pressure: if pix_ready_i stays low, issue stalls once credits are exhausted. No data is lost or duplicated.
- pix_data_o carries bits [23:0] only; bits [31:24] are ignored.

Test Plan:
- Basic frame: start with N=3, RAM[0..2]=0x00AABBCC, 0x00112233, 0x00445566, ready held high, ser_idle_i high, RESET_CYCLES=10 -> pixels 0xAABBCC, 0x112233, 0x445566 in order; exactly 3 handshakes; done_o pulses exactly once; busy_o falls in the same cycle.
- Back-pressure: N=8, ready toggling with a 1-in-4 duty -> all 8 pixels in order; pix_data_o stable whenever valid && !ready; FIFO count never exceeds 4 (assertion).
- Full frame: N=600 -> clamped to 512; ram_rdaddr_o ends at 511; 512 handshakes; no issue beyond 511.
- N=0 -> no reads issued, pix_valid_o never asserts; done_o pulses exactly RESET_CYCLES cycles after the start edge.
- Start during busy: second start_i pulse mid-STREAM -> ignored, frame count unchanged; single done_o.
- Serializer gating and reset abort:
  - ser_idle_i held low 20 cycles after the last handshake -> LATCH entered only after it rises.
  - rst_n_i asserted mid-STREAM -> all outputs at reset values immediately; no done_o.
  - A new start after reset runs cleanly from address 0.

Source files
------------

// File: rtl/neopix_frame_sequencer.sv
// Frame sequencer for a NeoPixel (WS2812) chain. Prefetches pixel words from the pixel RAM,
// absorbs the RAM's fixed read latency in a small skid FIFO, streams the pixels to the bit
// serializer over valid/ready, then holds the latch gap before flagging frame completion.
module neopix_frame_sequencer #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LATENCY   = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RESET_CYCLES = 15000
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W:0]   num_pixels_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] ram_rdaddr_o,
  input  logic [DATA_W-1:0] ram_q_i,
  output logic [23:0]       pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  input  logic              ser_idle_i
);

  localparam int unsigned NW     = ADDR_W + 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned InfW   = $clog2(RD_LATENCY + 1);
  localparam int unsigned SumW   = CntW + 1;
  localparam int unsigned LatchW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [ADDR_W:0]   MaxN      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LatchW-1:0] LatchLoad = LatchW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStream, StWaitIdle, StLatch} state_e;

  state_e              state_q;
  logic [ADDR_W:0]     n_q;
  logic [ADDR_W:0]     issue_cnt_q;
  logic [ADDR_W:0]     send_cnt_q;
  logic [LatchW-1:0]   latch_cnt_q;
  logic                busy_q;
  logic                done_q;
  logic [ADDR_W-1:0]   rdaddr_q;
  logic [RD_LATENCY-1:0] pipe_q;

  logic [23:0]         fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     fifo_cnt_q;

  logic [InfW-1:0]     inflight;
  logic [SumW-1:0]     credit_sum;
  logic                issue;
  logic                push;
  logic                pop;
  logic [ADDR_W:0]     n_load;
  logic                unused_ram_upper;

  // Count reads still travelling through the RAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight = inflight + InfW'(pipe_q[i]);
    end
  end

  // A read only goes out if its data is guaranteed a FIFO slot on arrival.
  assign credit_sum  = SumW'(fifo_cnt_q) + SumW'(inflight);
  assign issue       = (state_q == StStream) && (issue_cnt_q < n_q) &&
                       (credit_sum < SumW'(FIFO_DEPTH));
  assign push        = pipe_q[RD_LATENCY-1];
  assign pix_valid_o = (fifo_cnt_q != '0);
  assign pop         = pix_valid_o && pix_ready_i;
  assign pix_data_o  = fifo_mem_q[rd_ptr_q];
  assign n_load      = (num_pixels_i > MaxN) ? MaxN : num_pixels_i;

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign ram_rdaddr_o = rdaddr_q;

  // Only the GRB colour bits are carried; the top byte of each RAM word is dropped.
  assign unused_ram_upper = ^ram_q_i[DATA_W-1:24];

  // Read address register and the valid pipe that tracks RAM latency.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_q   <= '0;
      rdaddr_q <= '0;
    end else begin
      pipe_q[0] <= issue;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      if (issue) begin
        rdaddr_q <= issue_cnt_q[ADDR_W-1:0];
      end
    end
  end

  // Skid FIFO: RAM data in at the pipe output, pixels out on each handshake.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= ram_q_i[23:0];
        wr_ptr_q             <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Frame control: load, stream, wait for serializer drain, latch gap, done.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      n_q         <= '0;
      issue_cnt_q <= '0;
      send_cnt_q  <= '0;
      latch_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            n_q         <= n_load;
            issue_cnt_q <= '0;
            send_cnt_q  <= '0;
            busy_q      <= 1'b1;
            if (n_load == '0) begin
              latch_cnt_q <= LatchLoad;
              state_q     <= StLatch;
            end else begin
              state_q <= StStream;
            end
          end
        end
        StStream: begin
          if (issue) begin
            issue_cnt_q <= issue_cnt_q + NW'(1);
          end
          if (pop) begin
            send_cnt_q <= send_cnt_q + NW'(1);
          end
          if (send_cnt_q == n_q) begin
            state_q <= StWaitIdle;
          end
        end
        StWaitIdle: begin
          if (ser_idle_i) begin
            latch_cnt_q <= LatchLoad;
            state_q     <= StLatch;
          end
        end
        StLatch: begin
          if (latch_cnt_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            latch_cnt_q <= latch_cnt_q - LatchW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
